fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 153 +++++++++++++++
 tb/tb_fetch_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Decoupling queue between instruction fetch and decode. Each word returned
// by instruction memory is stored together with its PC in a small circular
// buffer. Decode sees the oldest entry at the head and pops it with
// dec_ready. The program counter unit advances only when a word is actually
// accepted (ihit && fetch_ready).
//
// A halt word (opcode 6'b111111) is still enqueued, but it freezes further
// fetching. Queued words keep draining to decode. Only a flush (redirect)
// or a reset leaves the halted state. A flush discards every queued word,
// including the word on imemload in the flush cycle.
//
// Parameters
//   DEPTH        number of queue entries (power of two, >= 2)
//
// Ports
//   CLK          system clock; all state changes on its rising edge
//   RST          synchronous active-high reset
//   ihit         instruction memory returned a valid word this cycle
//   imemload     instruction word from instruction memory
//   imemaddr     PC of the word on imemload
//   fetch_ready  queue can accept a word (registered state only)
//   flush        redirect; discards all queued words
//   valid        head entry is valid
//   dec_ready    decode consumes the head entry this cycle
//   instr        instruction at head (0 when not valid)
//   instr_pc     PC of head instruction (0 when not valid)
//   npc          instr_pc + 4 (0 when not valid)
//   count        number of occupied entries
//   halted       a halt word has been enqueued; fetching is frozen
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ihit,
    input  logic [31:0]              imemload,
    input  logic [31:0]              imemaddr,
    output logic                     fetch_ready,
    input  logic                     flush,
    output logic                     valid,
    input  logic                     dec_ready,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    output logic [31:0]              npc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [5:0]    HALT_OPCODE = 6'b111111;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // Storage is not reset: every output read from it is masked by valid.
    logic [63:0]   mem_q [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;

    logic          push;
    logic          pop;
    logic [63:0]   head_entry;

    // Handshake outputs come only from registers, so there is no
    // combinational path from dec_ready or flush to fetch_ready.
    always_comb begin
        fetch_ready = (count_q != FULL_COUNT) && (state_q == RUN);
        valid       = (count_q != '0);
        halted      = (state_q == HALT);
        count       = count_q;
    end

    // Head entry presentation; zeroed whenever the queue is empty.
    always_comb begin
        head_entry = mem_q[head_q];
        instr      = '0;
        instr_pc   = '0;
        npc        = '0;
        if (valid) begin
            instr    = head_entry[31:0];
            instr_pc = head_entry[63:32];
            npc      = head_entry[63:32] + 32'd4;
        end
    end

    // Next-state logic. Flush overrides any push or pop in the same cycle.
    // A full queue refuses a push even when a pop frees a slot this cycle,
    // because fetch_ready was already low and the PC unit held its PC.
    always_comb begin
        push    = ihit && fetch_ready && !flush;
        pop     = valid && dec_ready && !flush;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = RUN;
        end else begin
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // The halt word itself is enqueued; only later fetches stop.
            if (push && (imemload[31:26] == HALT_OPCODE)) begin
                state_d = HALT;
            end
        end
    end

    // Pointer, occupancy and RUN/HALT state registers. Reset wins over all.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Storage write at the tail slot on an accepted push.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem_q[tail_q] <= {imemaddr, imemload};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue. A behavioural model (a queue of
// {pc, word} pairs plus a halted flag) predicts every output each cycle.
// Directed scenarios pin the model with literal expectations, then a long
// randomized run compares DUT and model on every cycle.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ihit;
    logic [31:0]   imemload;
    logic [31:0]   imemaddr;
    logic          fetch_ready;
    logic          flush;
    logic          valid;
    logic          dec_ready;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic [31:0]   npc;
    logic [CW-1:0] count;
    logic          halted;

    int checks = 0;
    int passes = 0;

    // Reference model state: oldest entry at index 0.
    logic [63:0] mq[$];
    logic        m_halted = 1'b0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .imemload   (imemload),
        .imemaddr   (imemaddr),
        .fetch_ready(fetch_ready),
        .flush      (flush),
        .valid      (valid),
        .dec_ready  (dec_ready),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .npc        (npc),
        .count      (count),
        .halted     (halted)
    );

    always #5 CLK = ~CLK;

    // Single comparison point; uses === so X on an output is a failure.
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_fetch_ready();
        return (mq.size() != DEPTH) && !m_halted;
    endfunction

    // Drive one cycle of inputs, clock it, and advance the model by the
    // same rules the queue must obey.
    task automatic applyStimulus(input logic r, input logic ih, input logic [31:0] ld,
                                 input logic [31:0] ad, input logic fl, input logic dr);
        logic do_push;
        logic do_pop;
        RST       = r;
        ihit      = ih;
        imemload  = ld;
        imemaddr  = ad;
        flush     = fl;
        dec_ready = dr;
        do_push = ih && m_fetch_ready() && !fl;
        do_pop  = (mq.size() != 0) && dr && !fl;
        @(posedge CLK);
        if (r || fl) begin
            mq.delete();
            m_halted = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({ad, ld});
                if (ld[31:26] == 6'b111111) m_halted = 1'b1;
            end
        end
        #1;
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        e_valid = (mq.size() != 0);
        e_instr = e_valid ? mq[0][31:0] : 32'h0;
        e_pc    = e_valid ? mq[0][63:32] : 32'h0;
        e_npc   = e_valid ? mq[0][63:32] + 32'd4 : 32'h0;
        cmp("valid",       32'(valid),       32'(e_valid));
        cmp("instr",       instr,            e_instr);
        cmp("instr_pc",    instr_pc,         e_pc);
        cmp("npc",         npc,              e_npc);
        cmp("count",       32'(count),       32'(mq.size()));
        cmp("halted",      32'(halted),      32'(m_halted));
        cmp("fetch_ready", 32'(fetch_ready), 32'(m_fetch_ready()));
    endtask

    task automatic step(input logic r, input logic ih, input logic [31:0] ld,
                        input logic [31:0] ad, input logic fl, input logic dr);
        applyStimulus(r, ih, ld, ad, fl, dr);
        checkOutput();
    endtask

    task automatic doReset();
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        cmp({tag, "_valid"},  32'(valid),       32'd0);
        cmp({tag, "_halted"}, 32'(halted),      32'd0);
        cmp({tag, "_fready"}, 32'(fetch_ready), 32'd1);
        cmp({tag, "_count"},  32'(count),       32'd0);
        cmp({tag, "_instr"},  instr,            32'h0);
        cmp({tag, "_pc"},     instr_pc,         32'h0);
        cmp({tag, "_npc"},    npc,              32'h0);
    endtask

    initial begin
        logic [31:0] pc;
        logic        r, ih, fl, dr;
        logic [31:0] ld;
        logic        accepted;

        RST = 1'b0; ihit = 1'b0; imemload = '0; imemaddr = '0;
        flush = 1'b0; dec_ready = 1'b0;
        @(negedge CLK);

        // Reset state
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkResetValues("reset");

        // Single fetch: one-cycle latency
        step(1'b0, 1'b1, 32'h20010005, 32'h0, 1'b0, 1'b0);
        cmp("single_valid", 32'(valid),  32'd1);
        cmp("single_instr", instr,       32'h20010005);
        cmp("single_pc",    instr_pc,    32'h0);
        cmp("single_npc",   npc,         32'h4);
        cmp("single_count", 32'(count),  32'd1);

        // Fill to full, then a fifth ihit is refused
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 1'b1, 32'h00A00000 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
        end
        cmp("full_count",  32'(count),       32'd4);
        cmp("full_fready", 32'(fetch_ready), 32'd0);
        step(1'b0, 1'b1, 32'h00B00000, 32'h10, 1'b0, 1'b0);
        cmp("full_5th_count", 32'(count), 32'd4);
        cmp("full_head_pc",   instr_pc,   32'h0);
        // Pop while full with ihit: word still refused
        step(1'b0, 1'b1, 32'h00B00000, 32'h10, 1'b0, 1'b1);
        cmp("full_pop_count", 32'(count), 32'd3);
        cmp("full_pop_pc",    instr_pc,   32'h4);

        // Streaming across pointer wrap
        doReset();
        step(1'b0, 1'b1, 32'h10000000, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 32'h10000000 + 32'(i), 32'(4 * i), 1'b0, 1'b1);
            cmp("stream_count", 32'(count), 32'd1);
            cmp("stream_pc",    instr_pc,   32'(4 * i));
        end

        // Empty queue ignores dec_ready
        doReset();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cmp("empty_pop_count", 32'(count), 32'd0);

        // Flush with push and pop in the same cycle
        doReset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h30000000 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
        end
        cmp("preflush_count", 32'(count), 32'd3);
        step(1'b0, 1'b1, 32'h3DEADBEE, 32'hC, 1'b1, 1'b1);
        cmp("flush_count", 32'(count), 32'd0);
        cmp("flush_valid", 32'(valid), 32'd0);
        cmp("flush_instr", instr,      32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cmp("flush_word_absent", 32'(count), 32'd0);

        // Halt word freezes fetch, queue drains, flush resumes
        doReset();
        step(1'b0, 1'b1, 32'h40000001, 32'h8, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h40000002, 32'hC, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hFFFFFFFF, 32'h10, 1'b0, 1'b0);
        cmp("halt_halted", 32'(halted),      32'd1);
        cmp("halt_fready", 32'(fetch_ready), 32'd0);
        cmp("halt_count",  32'(count),       32'd3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h41000000, 32'h14, 1'b0, 1'b1);
        end
        cmp("halt_drained_count",  32'(count),  32'd0);
        cmp("halt_drained_halted", 32'(halted), 32'd1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cmp("halt_flush_halted", 32'(halted),      32'd0);
        cmp("halt_flush_fready", 32'(fetch_ready), 32'd1);

        // Reset mid-operation while halted, with everything else asserted
        step(1'b0, 1'b1, 32'h50000000, 32'h20, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hFC000000, 32'h24, 1'b0, 1'b0);
        cmp("prerst_count",  32'(count),  32'd2);
        cmp("prerst_halted", 32'(halted), 32'd1);
        step(1'b1, 1'b1, 32'h12345678, 32'h28, 1'b1, 1'b1);
        checkResetValues("midrst");

        // Randomized run against the model
        pc = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 29) == 0);
            ih = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            ld = $urandom;
            if ($urandom_range(0, 39) == 0) ld[31:26] = 6'b111111;
            else if (ld[31:26] == 6'b111111) ld[31:26] = 6'b000000;
            accepted = ih && m_fetch_ready() && !fl && !r;
            step(r, ih, ld, pc, fl, dr);
            if (r) pc = 32'h0;
            else if (fl) pc = {$urandom_range(0, 32'h3FFF), 2'b00};
            else if (accepted) pc = pc + 32'd4;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
